// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_pkg
// Brief    : Shared constants and types for the pixel stream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

    localparam int DEF_CHANNELS = 3;
    localparam int DEF_CH_W     = 8;

    // Positions of the timing bits inside the 3-bit field stored above the pixel
    localparam int HS_BIT = 0;
    localparam int VS_BIT = 1;
    localparam int DE_BIT = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FLUSH   = 2'd2
    } resync_state_e;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_mem
// Brief    : Simple dual-port register array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo_mem
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH = DEF_CHANNELS * DEF_CH_W + 3,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pixel_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_fifo
// Brief    : Show-ahead pixel FIFO carrying hsync/vsync/de with each pixel.
//            Define PIXEL_FIFO_RESYNC_EN to add the frame resync FSM.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_fifo
    import pixel_stream_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_W     = DEF_CH_W,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic                       pclk,
    input  logic                       rstbtn_n,
    input  logic                       in_valid,
    input  logic [CHANNELS*CH_W-1:0]   in_pixel,
    input  logic                       in_hsync,
    input  logic                       in_vsync,
    input  logic                       in_de,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*CH_W-1:0]   out_pixel,
    output logic                       out_hsync,
    output logic                       out_vsync,
    output logic                       out_de,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int c_PIX_W  = CHANNELS * CH_W;
    localparam int c_WORD_W = c_PIX_W + 3;
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam logic [c_LVL_W-1:0] c_AFULL = c_LVL_W'(AFULL_TH);

    logic [c_PTR_W-1:0]  r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0]  r_rptr_q, w_rptr_d;
    logic [c_LVL_W-1:0]  r_level_q, w_level_d;
    logic                r_out_valid_q, w_out_valid_d;
    logic [c_WORD_W-1:0] r_out_word_q, w_out_word_d;
    logic                r_overflow_q, w_overflow_d;

    logic                w_full, w_pop, w_push, w_drop;
    logic                w_block, w_flush;
    logic                w_mem_we;
    logic [c_ADDR_W-1:0] w_mem_waddr, w_mem_raddr;
    logic [c_WORD_W-1:0] w_mem_wdata, w_mem_rdata;

    assign w_mem_wdata = {in_de, in_vsync, in_hsync, in_pixel};
    assign w_full      = (r_wptr_q[c_ADDR_W] != r_rptr_q[c_ADDR_W]) &&
                         (r_wptr_q[c_ADDR_W-1:0] == r_rptr_q[c_ADDR_W-1:0]);
    assign w_pop       = r_out_valid_q & out_ready;
    assign w_push      = in_valid & ~w_block & (~w_full | w_pop);
    assign w_drop      = in_valid & ~w_block & w_full & ~w_pop;

`ifdef PIXEL_FIFO_RESYNC_EN
    resync_state_e r_state_q, w_state_d;
    logic          r_prev_vs_q, w_prev_vs_d;
    logic          w_vs_rise;

    // Rising vsync is judged against the previous valid word, whatever the state
    assign w_vs_rise   = in_valid & in_vsync & ~r_prev_vs_q;
    assign w_prev_vs_d = in_valid ? in_vsync : r_prev_vs_q;
    assign w_block     = (r_state_q == ST_WAIT_VS);
    assign w_flush     = w_block & w_vs_rise;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_RUN:     if (w_drop)    w_state_d = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_rise) w_state_d = ST_FLUSH;
            ST_FLUSH:                  w_state_d = ST_RUN;
            default:                   w_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge pclk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_state_q   <= ST_RUN;
            r_prev_vs_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_prev_vs_q <= w_prev_vs_d;
        end
    end
`else
    assign w_block = 1'b0;
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_wptr_d      = r_wptr_q + c_PTR_W'(w_push);
        w_rptr_d      = r_rptr_q + c_PTR_W'(w_pop);
        w_level_d     = r_level_q + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        // Only words already stored before this edge may become the head next cycle
        w_out_valid_d = (r_level_q - c_LVL_W'(w_pop)) != '0;
        w_mem_we      = w_push;
        w_mem_waddr   = r_wptr_q[c_ADDR_W-1:0];
        w_overflow_d  = w_drop ? 1'b1 : (clr_overflow ? 1'b0 : r_overflow_q);
        // The vsync-rising word restarts the FIFO from entry 0
        if (w_flush) begin
            w_wptr_d      = c_PTR_W'(1);
            w_rptr_d      = '0;
            w_level_d     = c_LVL_W'(1);
            w_out_valid_d = 1'b0;
            w_mem_we      = 1'b1;
            w_mem_waddr   = '0;
        end
    end

    assign w_mem_raddr = w_rptr_d[c_ADDR_W-1:0];

    always_comb begin
        w_out_word_d = r_out_word_q;
        if (w_out_valid_d) begin
            w_out_word_d = w_mem_rdata;
        end
    end

    always_ff @(posedge pclk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_level_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_word_q  <= '0;
            r_overflow_q  <= 1'b0;
        end else begin
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_level_q     <= w_level_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_word_q  <= w_out_word_d;
            r_overflow_q  <= w_overflow_d;
        end
    end

    pixel_fifo_mem #(
        .WIDTH (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign out_valid   = r_out_valid_q;
    assign out_pixel   = r_out_word_q[c_PIX_W-1:0];
    assign out_hsync   = r_out_word_q[c_PIX_W + HS_BIT];
    assign out_vsync   = r_out_word_q[c_PIX_W + VS_BIT];
    assign out_de      = r_out_word_q[c_PIX_W + DE_BIT];
    assign level       = r_level_q;
    assign almost_full = (r_level_q >= c_AFULL);
    assign overflow    = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_fifo
// Brief    : Self-checking bench for pixel_stream_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_fifo;

    localparam int CHANNELS = 3;
    localparam int CH_W     = 8;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;
    localparam int PW       = CHANNELS * CH_W;
    localparam int LW       = $clog2(DEPTH) + 1;
`ifdef PIXEL_FIFO_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rstbtn_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_pixel = '0;
    logic          in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          out_valid, out_hsync, out_vsync, out_de;
    logic [PW-1:0] out_pixel;
    logic [LW-1:0] level;
    logic          almost_full, overflow;

    pixel_stream_fifo #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .pclk         (pclk),
        .rstbtn_n     (rstbtn_n),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_hsync     (in_hsync),
        .in_vsync     (in_vsync),
        .in_de        (in_de),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync),
        .out_de       (out_de),
        .level        (level),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a queue of words, each stamped with the edge that stored it.
    // A word becomes visible at the head one cycle after it was stored.
    logic [PW+2:0] mq[$];
    int            mst[$];
    int            cyc = 0;
    bit            m_valid = 0, m_ovf = 0, m_disc = 0, m_prev_vs = 0;
    bit            m_pop, m_drop, m_rise;
    logic [PW+2:0] m_word;

    always @(posedge pclk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            mq.delete(); mst.delete();
            m_valid = 0; m_ovf = 0; m_disc = 0; m_prev_vs = 0;
        end else begin
            cyc++;
            m_word = {in_de, in_vsync, in_hsync, in_pixel};
            m_pop  = m_valid && out_ready;
            m_drop = 0;
            m_rise = in_valid && in_vsync && !m_prev_vs;
            if (RESYNC && m_disc) begin
                if (m_pop) begin void'(mq.pop_front()); void'(mst.pop_front()); end
                if (m_rise) begin
                    mq.delete(); mst.delete();
                    mq.push_back(m_word); mst.push_back(cyc);
                    m_disc = 0;
                end
            end else begin
                m_drop = in_valid && (mq.size() == DEPTH) && !m_pop;
                if (m_pop) begin void'(mq.pop_front()); void'(mst.pop_front()); end
                if (in_valid && !m_drop) begin mq.push_back(m_word); mst.push_back(cyc); end
                if (m_drop && RESYNC) m_disc = 1;
            end
            if (m_drop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            if (in_valid) m_prev_vs = in_vsync;
            m_valid = (mq.size() > 0) && (mst[0] != cyc);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge pclk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("level", 32'(level), 32'(mq.size()));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL_TH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (!rstbtn_n)
            chk("reset_out_word", 32'({out_de, out_vsync, out_hsync, out_pixel}), 32'(0));
        else if (m_valid)
            chk("out_word", 32'({out_de, out_vsync, out_hsync, out_pixel}), 32'(mq[0]));
    end

    task automatic drive(input bit v, input logic [PW-1:0] p, input bit hs, input bit vs,
                         input bit de, input bit rdy);
        in_valid = v; in_pixel = p; in_hsync = hs; in_vsync = vs; in_de = de; out_ready = rdy;
        @(negedge pclk);
    endtask

    logic [PW-1:0] first_pix;

    initial begin
        #1 rstbtn_n = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_almost_full", 32'(almost_full), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_out_pixel", 32'(out_pixel), 32'(0));
        rstbtn_n = 1'b1;

        // Single word with one-cycle show-ahead latency
        drive(1, 24'hA1B2C3, 0, 0, 1, 0);
        chk("single_level_1", 32'(level), 32'(1));
        chk("single_not_yet_valid", 32'(out_valid), 32'(0));
        drive(0, '0, 0, 0, 0, 0);
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_pixel", 32'(out_pixel), 32'hA1B2C3);
        chk("single_de", 32'(out_de), 32'(1));
        drive(0, '0, 0, 0, 0, 1);
        chk("single_level_0", 32'(level), 32'(0));
        chk("single_empty", 32'(out_valid), 32'(0));

        // Fill with the sink stalled
        first_pix = 24'h100001;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, (i == 1) ? first_pix : PW'($urandom), 1'($urandom), 0, 1, 0);
            if (i == AFULL_TH - 1) chk("afull_below_th", 32'(almost_full), 32'(0));
            if (i == AFULL_TH)     chk("afull_at_th", 32'(almost_full), 32'(1));
        end
        chk("fill_level_16", 32'(level), 32'(16));
        chk("fill_head", 32'(out_pixel), 32'(first_pix));

        // Streaming through a full FIFO across pointer wrap
        for (int i = 0; i < 32; i++)
            drive(1, PW'($urandom), 1'($urandom), 0, 1'($urandom), 1);
        chk("stream_level_16", 32'(level), 32'(16));
        chk("stream_no_overflow", 32'(overflow), 32'(0));

        // Write into a full FIFO with no read is lost
        drive(1, 24'h0BAD01, 0, 0, 1, 0);
        chk("drop_overflow", 32'(overflow), 32'(1));
        chk("drop_level", 32'(level), 32'(16));

        for (int i = 0; i < 5; i++) drive(1, PW'($urandom), 0, 0, 1, 0);
`ifdef PIXEL_FIFO_RESYNC_EN
        drive(1, 24'h00C0DE, 0, 1, 1, 0);
        chk("flush_level_1", 32'(level), 32'(1));
        chk("flush_out_invalid", 32'(out_valid), 32'(0));
        drive(0, '0, 0, 0, 0, 0);
        chk("resync_first_valid", 32'(out_valid), 32'(1));
        chk("resync_first_pixel", 32'(out_pixel), 32'h00C0DE);
        chk("resync_first_vsync", 32'(out_vsync), 32'(1));
        chk("resync_ovf_sticky", 32'(overflow), 32'(1));
`else
        drive(1, 24'h00C0DE, 0, 1, 1, 0);
        chk("nors_overflow", 32'(overflow), 32'(1));
        chk("nors_level_16", 32'(level), 32'(16));
        drive(0, '0, 0, 0, 0, 1);
        chk("nors_level_15", 32'(level), 32'(15));
        drive(1, 24'h00BEEF, 0, 0, 1, 0);
        chk("nors_resume_level", 32'(level), 32'(16));
        chk("nors_ovf_sticky", 32'(overflow), 32'(1));
`endif
        clr_overflow = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        clr_overflow = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'(0));

        // Random traffic with backpressure
        repeat (20) drive(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            clr_overflow = ($urandom_range(0, 19) == 0);
            drive(1'($urandom), PW'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom), ($urandom_range(0, 9) < 6));
        end
        clr_overflow = 1'b0;

        // Asynchronous reset with seven words stored
        repeat (20) drive(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) drive(1, PW'($urandom), 0, 0, 1, 0);
        chk("pre_reset_level_7", 32'(level), 32'(7));
        #2 rstbtn_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'(0));
        chk("async_rst_level", 32'(level), 32'(0));
        chk("async_rst_pixel", 32'(out_pixel), 32'(0));
        @(negedge pclk);
        @(negedge pclk);
        rstbtn_n = 1'b1;
        drive(1, 24'h5A5A5A, 1, 0, 1, 0);
        chk("post_rst_level", 32'(level), 32'(1));
        chk("post_rst_not_valid", 32'(out_valid), 32'(0));
        drive(0, '0, 0, 0, 0, 0);
        chk("post_rst_valid", 32'(out_valid), 32'(1));
        chk("post_rst_pixel", 32'(out_pixel), 32'h5A5A5A);
        chk("post_rst_hsync", 32'(out_hsync), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
